// File: rtl/ofm_writeback_pkg.sv
// Shared accelerator definitions: default element geometry, layer types and
// the output-writeback FSM state encoding.
package ofm_writeback_pkg;

    localparam int unsigned ACC_DATA_W = 8;
    localparam int unsigned ACC_LANES  = 4;

    localparam logic [1:0] CONVOL = 2'd0;
    localparam logic [1:0] FULLY  = 2'd1;
    localparam logic [1:0] POOL   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/ofm_writeback_wb_fifo.sv
// Packed-word FIFO with registered full flag and a registered head-of-queue
// output, so a pushed word appears on rvalid/rdata the following cycle.
module wb_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full_nxt_c,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] head_nxt;

    // Next head: the word being written bypasses the array when it lands at the new read pointer.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && rvalid;
        rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count + CW'(push_ok) - CW'(pop_ok);
        full_nxt_c = (count_nxt == CW'(DEPTH));
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wdata;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= full_nxt_c;
            rvalid <= (count_nxt != '0);
            rdata  <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// Output feature-map writeback: packs signed elements LANES per word, lane 0
// in the LSBs, and streams the words through a small FIFO to memory.
module ofm_writeback
    import ofm_writeback_pkg::*;
#(
    parameter int unsigned DATA_W     = ACC_DATA_W,
    parameter int unsigned LANES      = ACC_LANES,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          ofm_count,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned WORD_W = DATA_W * LANES;
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;

    wb_state_t          state;
    wb_state_t          state_nxt;
    logic [CNT_W-1:0]   remaining;
    logic [LW-1:0]      lane;
    logic [WORD_W-1:0]  acc;
    logic [WORD_W-1:0]  word_c;
    logic               accept_c;
    logic               last_elem_c;
    logic               push_c;
    logic               pop_c;
    logic               fifo_full_nxt;
    logic [WORD_W:0]    fifo_rdata;

    assign accept_c    = in_valid && in_ready;
    assign last_elem_c = accept_c && (remaining == CNT_W'(1));
    assign push_c      = accept_c && (last_elem_c || (lane == LW'(LANES - 1)));
    assign pop_c       = out_valid && out_ready;

    // Merge the incoming element into its lane; lanes not yet filled stay zero.
    always_comb begin
        word_c = acc;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane == LW'(k)) begin
                word_c[k*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (ofm_count == '0) ? DONE : PACK;
                end
            end
            PACK: begin
                if (last_elem_c) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Element counter, lane packing and status flags registered from next state.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            remaining <= '0;
            lane      <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                remaining <= ofm_count;
            end else if (accept_c) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (push_c) begin
                lane <= '0;
                acc  <= '0;
            end else if (accept_c) begin
                lane <= lane + LW'(1);
                acc  <= word_c;
            end
            in_ready <= (state_nxt == PACK) && !fifo_full_nxt;
            busy     <= (state_nxt == PACK) || (state_nxt == DRAIN);
            done     <= (state_nxt == DONE);
        end
    end

    wb_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .wdata      ({last_elem_c, word_c}),
        .pop        (pop_c),
        .full_nxt_c (fifo_full_nxt),
        .rvalid     (out_valid),
        .rdata      (fifo_rdata)
    );

    assign out_data = fifo_rdata[WORD_W-1:0];
    assign out_last = fifo_rdata[WORD_W];

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: directed scenarios plus randomized
// maps compared against a word-level packing model.
module tb_ofm_writeback;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WORD_W     = DATA_W * LANES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  ofm_count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              done;

    ofm_writeback #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ofm_count (ofm_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] elems [0:63];
    logic [WORD_W-1:0] exp_data [$];
    logic              exp_last [$];
    logic [WORD_W-1:0] got_data [$];
    logic              got_last [$];
    int checks = 0;
    int errors = 0;
    int stall_viol, over_viol, busy_viol, done_gap, sent_cnt;
    bit done_seen;

    // Reference: element i lands in lane i%LANES of word i/LANES; last word flagged.
    function automatic void build_expected(input int n);
        logic [WORD_W-1:0] w;
        w = '0;
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < n; i++) begin
            w = w | (WORD_W'(elems[i]) << (DATA_W * (i % LANES)));
            if ((i % LANES) == LANES - 1 || i == n - 1) begin
                exp_data.push_back(w);
                exp_last.push_back(i == n - 1);
                w = '0;
            end
        end
    endfunction

    task automatic pulse_start(input int n);
        got_data.delete();
        got_last.delete();
        @(posedge clk); #1;
        start = 1'b1;
        ofm_count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds elements sent0..n-1, drains words with random out_ready, stops at done.
    task automatic stream(input int n, input int sent0, input int rdy_pct, input int ghost_cyc);
        int sent;
        int last_hs;
        bit prev_stall;
        logic [WORD_W-1:0] prev_data;
        logic prev_last;
        sent = sent0; last_hs = -100; prev_stall = 0; prev_data = '0; prev_last = 0;
        stall_viol = 0; over_viol = 0; busy_viol = 0; done_seen = 0; done_gap = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            if (done === 1'b1) begin
                done_seen = 1;
                done_gap = cyc - last_hs;
                if (busy !== 1'b0) busy_viol++;
                break;
            end
            if (busy !== 1'b1) busy_viol++;
            if (in_ready === 1'b1 && sent >= n) over_viol++;
            if (cyc == ghost_cyc) begin
                start = 1'b1;
                ofm_count = CNT_W'(3);
            end else begin
                start = 1'b0;
            end
            out_ready = (int'($urandom_range(99)) < rdy_pct);
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_hs = cyc;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            in_valid = (sent < n) && ($urandom_range(3) != 0 || rdy_pct == 100);
            in_data = (sent < n) ? elems[sent] : '0;
            if (in_valid && in_ready === 1'b1) sent++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sent_cnt = sent;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; ofm_count = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_last, in_ready, busy, done} !== 5'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b ir=%b busy=%b done=%b data=%h, want all 0",
                     out_valid, out_last, in_ready, busy, done, out_data);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ir=%b busy=%b v=%b, want 0 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_aligned();
        for (int i = 0; i < 8; i++) elems[i] = DATA_W'(i + 1);
        pulse_start(8);
        stream(8, 0, 100, -1);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL aligned_timeout: no done seen"); end
        checks++;
        if (got_data.size() != 2) begin
            errors++; $display("FAIL aligned_count: got %0d words, want 2", got_data.size());
        end
        checks++;
        if (got_data.size() < 1 || got_data[0] !== 32'h04030201 || got_last[0] !== 1'b0) begin
            errors++; $display("FAIL aligned_word0: got %h, want 04030201 last 0", (got_data.size() > 0) ? got_data[0] : '0);
        end
        checks++;
        if (got_data.size() < 2 || got_data[1] !== 32'h08070605 || got_last[1] !== 1'b1) begin
            errors++; $display("FAIL aligned_word1: got %h, want 08070605 last 1", (got_data.size() > 1) ? got_data[1] : '0);
        end
        checks++;
        if (done_gap != 1) begin errors++; $display("FAIL aligned_done_gap: got %0d, want 1", done_gap); end
        checks++;
        if (busy_viol != 0 || over_viol != 0) begin
            errors++; $display("FAIL aligned_flags: busy_viol %0d over_viol %0d, want 0 0", busy_viol, over_viol);
        end
    endtask

    task automatic test_partial();
        elems[0] = 8'hFF; elems[1] = 8'h02; elems[2] = 8'h03; elems[3] = 8'h04; elems[4] = 8'hFB;
        pulse_start(5);
        stream(5, 0, 100, -1);
        checks++;
        if (!done_seen || got_data.size() != 2) begin
            errors++; $display("FAIL partial_count: done %0d words %0d, want 1 2", done_seen, got_data.size());
        end
        checks++;
        if (got_data.size() < 1 || got_data[0] !== 32'h040302FF || got_last[0] !== 1'b0) begin
            errors++; $display("FAIL partial_word0: got %h, want 040302ff last 0", (got_data.size() > 0) ? got_data[0] : '0);
        end
        checks++;
        if (got_data.size() < 2 || got_data[1] !== 32'h000000FB || got_last[1] !== 1'b1) begin
            errors++; $display("FAIL partial_word1: got %h, want 000000fb last 1", (got_data.size() > 1) ? got_data[1] : '0);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int holds;
        bit held_seen;
        logic [WORD_W-1:0] held;
        sent = 0; holds = 0; held_seen = 0; held = '0;
        for (int i = 0; i < 24; i++) elems[i] = DATA_W'(i + 1);
        build_expected(24);
        pulse_start(24);
        for (int c = 0; c < 30; c++) begin
            out_ready = 1'b0;
            in_valid = (sent < 24);
            in_data = elems[sent];
            if (in_valid && in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                if (held_seen && out_data !== held) holds++;
                held = out_data;
                held_seen = 1;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 16 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepted: got %0d elems in_ready=%b, want 16 and 0", sent, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_last !== 1'b0 || holds != 0) begin
            errors++; $display("FAIL bp_hold: got v=%b data=%h changes=%0d, want 1 04030201 0", out_valid, out_data, holds);
        end
        stream(24, 16, 100, -1);
        checks++;
        if (!done_seen || got_data.size() != 6) begin
            errors++; $display("FAIL bp_count: done %0d words %0d, want 1 6", done_seen, got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL bp_word%0d: got %h/%b, want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        pulse_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b v=%b ir=%b, want 1 0 0 0", done, busy, out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%b busy=%b v=%b, want 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 8; i++) elems[i] = DATA_W'($urandom);
        build_expected(8);
        pulse_start(8);
        stream(8, 0, 100, 2);
        checks++;
        if (!done_seen || got_data.size() != 2 || sent_cnt != 8) begin
            errors++; $display("FAIL ghost_count: done %0d words %0d sent %0d, want 1 2 8", done_seen, got_data.size(), sent_cnt);
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL ghost_word%0d: got %h/%b, want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_map();
        int sent;
        int guard;
        sent = 0; guard = 0;
        for (int i = 0; i < 8; i++) elems[i] = DATA_W'(i + 1);
        pulse_start(8);
        while (sent < 6 && guard < 100) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data = elems[sent];
            if (in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, in_ready, busy, done} !== 5'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b l=%b ir=%b busy=%b done=%b data=%h, want all 0",
                     out_valid, out_last, in_ready, busy, done, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_empty: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
        for (int i = 0; i < 4; i++) elems[i] = DATA_W'($urandom);
        build_expected(4);
        pulse_start(4);
        stream(4, 0, 70, -1);
        checks++;
        if (!done_seen || got_data.size() != 1) begin
            errors++; $display("FAIL midreset_count: done %0d words %0d, want 1 1", done_seen, got_data.size());
        end
        checks++;
        if (got_data.size() < 1 || got_data[0] !== exp_data[0] || got_last[0] !== 1'b1) begin
            errors++; $display("FAIL midreset_word: got %h, want %h last 1", (got_data.size() > 0) ? got_data[0] : '0, exp_data[0]);
        end
    endtask

    task automatic test_random();
        int n;
        int rdy;
        for (int m = 0; m < 6; m++) begin
            n = int'($urandom_range(40, 1));
            rdy = int'($urandom_range(100, 25));
            for (int i = 0; i < n; i++) elems[i] = DATA_W'($urandom);
            build_expected(n);
            pulse_start(n);
            stream(n, 0, rdy, -1);
            checks++;
            if (!done_seen || got_data.size() != exp_data.size() || sent_cnt != n) begin
                errors++; $display("FAIL rand%0d_count: done %0d words %0d sent %0d, want 1 %0d %0d",
                                   m, done_seen, got_data.size(), sent_cnt, exp_data.size(), n);
            end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++; $display("FAIL rand%0d_word%0d: got %h/%b, want %h/%b",
                                       m, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                end
            end
            checks++;
            if (done_gap != 1 || stall_viol != 0 || over_viol != 0 || busy_viol != 0) begin
                errors++; $display("FAIL rand%0d_protocol: gap %0d stall %0d over %0d busy %0d, want 1 0 0 0",
                                   m, done_gap, stall_viol, over_viol, busy_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_partial();
        test_backpressure();
        test_zero_count();
        test_start_ignored();
        test_reset_mid_map();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofm_writeback.md
OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed OFM element width.
REQ-002 SHALL have parameter LANES, default 4, elements packed per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries (power of 2).
REQ-004 SHALL have parameter CNT_W, default 16, element counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst_n. rst_n keeps the codebase name but is active-high.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  async reset, active-high.
- start  in  1  one-cycle pulse that begins a feature map.
- ofm_count  in  CNT_W  number of elements in the map, sampled on start.
- in_valid  in  1  upstream element valid.
- in_data  in  DATA_W  signed element from the OFM buffer.
- in_ready  out  1  element accepted when in_valid&&in_ready.
- out_valid  out  1  packed word valid.
- out_data  out  DATA_W*LANES  packed word.
- out_last  out  1  final word of the map.
- out_ready  in  1  downstream accepts.
- busy  out  1  map in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL implement the FSM states IDLE, PACK, DRAIN and DONE.
- IDLE->PACK on start with ofm_count>0.
- IDLE->DONE on start with ofm_count==0.
- PACK->DRAIN when the last element is accepted.
- DRAIN->DONE when the out_last word handshakes.
- DONE->IDLE unconditionally after one cycle.
REQ-008 SHALL ignore start outside IDLE.
REQ-009 SHALL drive in_ready=1 only in PACK with the FIFO not full; the FIFO full flag is registered, and a same-cycle pop does not enable a push.
REQ-010 SHALL place the element accepted k-th within a word (k=0..LANES-1) at out_data bits [k*DATA_W +: DATA_W], so lane 0 is in the LSBs.
REQ-011 SHALL push a word into the FIFO in the same cycle its LANES-th element, or the map's final element, is accepted.
REQ-012 SHALL zero-fill the unused upper lanes of a partial final word.
REQ-013 SHALL present a word on out_valid exactly one cycle after the push (FIFO registered output).
REQ-014 SHALL tag only the map's final word with out_last=1 and carry the tag through the FIFO.
REQ-015 SHALL hold out_data and out_last stable while out_valid&&!out_ready.
REQ-016 SHALL perform a FIFO pop when out_valid&&out_ready; a simultaneous push and pop leaves the occupancy unchanged.
REQ-017 SHALL decrement the remaining-element counter once per accepted element and never accept more than ofm_count elements.
REQ-018 SHALL drive busy=1 in PACK and DRAIN only.
REQ-019 SHALL pulse done=1 for exactly the one DONE cycle.
REQ-020 SHALL emit ceil(ofm_count/LANES) words per map, with no data loss under arbitrary out_ready stalls.

Reset
REQ-021 SHALL, on rst_n=1 at any time including mid-map, asynchronously force:
- state=IDLE, FIFO empty;
- lane index and counter to 0;
- out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0, done=0.
REQ-022 SHALL discard any partial word held at reset.

Structure
REQ-023 SHALL take the FSM state enum and the default DATA_W/LANES values from the shared accelerator package; the layer-type constants CONVOL/FULLY/POOL also live there.
REQ-024 SHALL implement the word FIFO as one sub-module, wb_fifo (push/pop, registered full/empty, registered output).
REQ-025 SHALL fit within 120-400 lines of RTL.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Aligned map: ofm_count=8, elements 1..8, out_ready=1 -> words 0x04030201 then 0x08070605 (second with out_last=1), then done one cycle after the second handshake.
- Partial word: ofm_count=5, elements -1,2,3,4,-5 -> words 0x0403_02FF then 0x0000_00FB with out_last=1.
- Backpressure: ofm_count=24, out_ready=0 -> in_ready drops after 16 elements (FIFO_DEPTH=4), out_data holds stable; with out_ready=1, all 6 words arrive in order.
- Zero count: start with ofm_count=0 -> no out_valid, done pulses one cycle later, busy stays 0.
- Start during a map: a second start in PACK with ofm_count=3 -> ignored, the original count completes.
- Reset mid-map: rst_n=1 after 6 of 8 elements -> all outputs 0 within the same cycle, FIFO empty; a following map with ofm_count=4 produces a single correct word.
